// File: rtl/fp_pkg.sv
// Shared types and constants for the binary32 add/sub front end.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int SUM_W  = 25;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int BIAS   = 127;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    ADD,
    HOLD
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W:0]   mant;
  } fp_unp_t;

endpackage

// File: rtl/fp_unpack.sv
// Splits a binary32 word into sign, exponent and hidden-bit mantissa; combinational.
// Denormals get hidden=0 and keep their raw exponent field of 0.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0] i_fp,
  output fp_unp_t     o_unp,
  output logic        o_is_inf_nan
);

  logic [EXP_W-1:0] w_exp;

  assign w_exp          = i_fp[30:23];
  assign o_unp.sign     = i_fp[31];
  assign o_unp.exp      = w_exp;
  assign o_unp.mant     = {(w_exp != '0), i_fp[MANT_W-1:0]};
  assign o_is_inf_nan   = (w_exp == EXP_MAX);

endmodule

// File: rtl/fp_align_add.sv
// Swap/align/add front end: result valid 1 + ceil(diff/SHIFT_STEP) cycles after accept.
// One operation in flight; result held in HOLD until out_ready, in_ready only in IDLE.
module fp_align_add
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP  = 4,
  parameter int ALIGN_LIMIT = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum,
  output logic [EXP_W-1:0] new_exponent,
  output logic             sign_a,
  output logic             sign_b,
  output logic             result_sign,
  output logic             exc_operand
);

  state_t r_state;
  state_t w_state_nxt;

  logic [MANT_W:0]  r_mx;
  logic [MANT_W:0]  r_my;
  logic [EXP_W-1:0] r_ex;
  logic [EXP_W-1:0] r_diff;
  logic             r_sx;
  logic             r_sy;
  logic             r_exc_lat;

  logic             r_out_valid;
  logic [SUM_W-1:0] r_sum;
  logic [EXP_W-1:0] r_new_exp;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_result_sign;
  logic             r_exc;

  fp_unp_t w_ua;
  fp_unp_t w_ub;
  fp_unp_t w_ub_eff;
  fp_unp_t w_x;
  fp_unp_t w_y;
  logic    w_exc_a;
  logic    w_exc_b;

  fp_unpack u_unpack_a (
    .i_fp         (a),
    .o_unp        (w_ua),
    .o_is_inf_nan (w_exc_a)
  );

  fp_unpack u_unpack_b (
    .i_fp         (b),
    .o_unp        (w_ub),
    .o_is_inf_nan (w_exc_b)
  );

  // Magnitude order is the plain {exp, frac} compare; a tie keeps A as X.
  logic             w_a_ge_b;
  logic [EXP_W-1:0] w_diff_raw;
  logic             w_flush;
  logic [EXP_W-1:0] w_diff_init;

  always_comb begin
    w_ub_eff      = w_ub;
    w_ub_eff.sign = w_ub.sign ^ op;
  end

  assign w_a_ge_b    = (a[30:0] >= b[30:0]);
  assign w_x         = w_a_ge_b ? w_ua : w_ub_eff;
  assign w_y         = w_a_ge_b ? w_ub_eff : w_ua;
  assign w_diff_raw  = w_x.exp - w_y.exp;
  assign w_flush     = (w_diff_raw >= EXP_W'(ALIGN_LIMIT));
  assign w_diff_init = w_flush ? '0 : w_diff_raw;

  logic [EXP_W-1:0] w_step;
  logic [EXP_W-1:0] w_diff_nxt;
  logic [MANT_W:0]  w_my_shift;

  assign w_step     = (r_diff < EXP_W'(SHIFT_STEP)) ? r_diff : EXP_W'(SHIFT_STEP);
  assign w_diff_nxt = r_diff - w_step;
  assign w_my_shift = r_my >> w_step;

  logic             w_same_sign;
  logic [SUM_W-1:0] w_add;
  logic [MANT_W:0]  w_sub;
  logic [SUM_W-1:0] w_sum;
  logic             w_rsign;

  assign w_same_sign = (r_sx == r_sy);
  assign w_add       = {1'b0, r_mx} + {1'b0, r_my};
  assign w_sub       = r_mx - r_my;
  assign w_sum       = w_same_sign ? w_add : {1'b0, w_sub};
  // An exact cancellation is reported as +0 regardless of operand order.
  assign w_rsign     = (!w_same_sign && (w_sub == '0)) ? 1'b0 : r_sx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (in_valid) w_state_nxt = (w_diff_init != '0) ? ALIGN : ADD;
      ALIGN: if (w_diff_nxt == '0) w_state_nxt = ADD;
      ADD:   w_state_nxt = HOLD;
      HOLD:  if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mx          <= '0;
      r_my          <= '0;
      r_ex          <= '0;
      r_diff        <= '0;
      r_sx          <= 1'b0;
      r_sy          <= 1'b0;
      r_exc_lat     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_sum         <= '0;
      r_new_exp     <= '0;
      r_sign_a      <= 1'b0;
      r_sign_b      <= 1'b0;
      r_result_sign <= 1'b0;
      r_exc         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mx      <= w_x.mant;
            r_my      <= w_flush ? '0 : w_y.mant;
            r_ex      <= w_x.exp;
            r_diff    <= w_diff_init;
            r_sx      <= w_x.sign;
            r_sy      <= w_y.sign;
            r_exc_lat <= w_exc_a | w_exc_b;
          end
        end
        ALIGN: begin
          r_my   <= w_my_shift;
          r_diff <= w_diff_nxt;
        end
        ADD: begin
          r_sum         <= w_sum;
          r_new_exp     <= r_ex;
          r_sign_a      <= r_sx;
          r_sign_b      <= r_sy;
          r_result_sign <= w_rsign;
          r_exc         <= r_exc_lat;
          r_out_valid   <= 1'b1;
        end
        HOLD: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = r_out_valid;
  assign sum          = r_sum;
  assign new_exponent = r_new_exp;
  assign sign_a       = r_sign_a;
  assign sign_b       = r_sign_b;
  assign result_sign  = r_result_sign;
  assign exc_operand  = r_exc;

endmodule

// File: tb/tb_fp_align_add.sv
// Scoreboard bench for fp_align_add with directed, hand-computed vectors.
module tb_fp_align_add;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] sum;
  logic [7:0]  new_exponent;
  logic        sign_a;
  logic        sign_b;
  logic        result_sign;
  logic        exc_operand;

  fp_align_add #(.SHIFT_STEP(4), .ALIGN_LIMIT(25)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .op           (op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sum          (sum),
    .new_exponent (new_exponent),
    .sign_a       (sign_a),
    .sign_b       (sign_b),
    .result_sign  (result_sign),
    .exc_operand  (exc_operand)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [24:0] sum;
    logic [7:0]  ex;
    logic        sa;
    logic        sb;
    logic        rs;
    logic        exc;
    int          lat;
    int          t0;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   have = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Every cycle the result is presented it must match the popped entry,
  // which also proves the outputs stay stable while out_ready is low.
  always @(negedge clk) begin
    if (!rst_n) begin
      have = 1'b0;
    end else if (out_valid) begin
      if (!have) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got sum 0x%0h, expected no result", sum);
        end else begin
          cur  = q.pop_front();
          have = 1'b1;
          chk("latency", 32'(cyc - cur.t0), 32'(cur.lat));
        end
      end
      if (have) begin
        chk("sum", 32'(sum), 32'(cur.sum));
        chk("new_exponent", 32'(new_exponent), 32'(cur.ex));
        chk("sign_a", 32'(sign_a), 32'(cur.sa));
        chk("sign_b", 32'(sign_b), 32'(cur.sb));
        chk("result_sign", 32'(result_sign), 32'(cur.rs));
        chk("exc_operand", 32'(exc_operand), 32'(cur.exc));
        if (out_ready) have = 1'b0;
      end
    end
  end

  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                      input logic [24:0] esum, input logic [7:0] eex,
                      input logic esa, input logic esb, input logic ers, input logic eexc,
                      input int elat, input bit push);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    op       = vop;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.sum = esum; e.ex = eex; e.sa = esa; e.sb = esb; e.rs = ers; e.exc = eexc;
    e.lat = elat; e.t0 = cyc;
    if (push) q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((q.size() != 0 || out_valid || have) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(q.size()), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'd0);
    chk({tag, "_new_exponent"}, 32'(new_exponent), 32'd0);
    chk({tag, "_signs"}, 32'({sign_a, sign_b, result_sign}), 32'd0);
    chk({tag, "_exc"}, 32'(exc_operand), 32'd0);
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;

    //   a             b             op  sum         exp    sa    sb    rs    exc  lat
    send(32'h3F800000, 32'h3F800000, 0, 25'h1000000, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
    send(32'h3F800000, 32'h3F000000, 0, 25'h0C00000, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1);
    send(32'h3F000000, 32'hBF800000, 0, 25'h0400000, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1);
    send(32'h3F800000, 32'h3F800000, 1, 25'h0000000, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1);
    send(32'h4B800000, 32'h3F000000, 0, 25'h0800000, 8'h97, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
    send(32'h43800000, 32'h3F000000, 0, 25'h0804000, 8'h87, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1);
    send(32'h4B800000, 32'h3F800000, 0, 25'h0800000, 8'h97, 1'b0, 1'b0, 1'b0, 1'b0, 7, 1);
    send(32'h3F800000, 32'h3F400000, 1, 25'h0200000, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1);
    send(32'h3F400000, 32'h3F800000, 1, 25'h0200000, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1);
    drain();

    // Infinity operand, then stall the consumer for five cycles.
    out_ready = 1'b0;
    send(32'h7F800000, 32'h3F800000, 0, 25'h0800000, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid_kept", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    drain();

    // Abort during ALIGN: nothing may come out for this operation.
    send(32'h41200000, 32'h3F800000, 0, 25'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("abort");
    @(negedge clk);
    chk_zero_outputs("abort_held");
    rst_n = 1'b1;
    send(32'h41200000, 32'h3F800000, 0, 25'h0B00000, 8'h82, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_align_add.md
Name: fp_align_add

Overview:
- Pre-normalisation front end of the single-precision add/sub datapath.
- Accepts two IEEE-754 binary32 operands and an add/sub opcode through a valid/ready handshake.
- Unpacks, swaps and aligns the operands over several cycles (iterative right shift), then adds or subtracts the 24-bit mantissas.
- Produces the 25-bit raw sum, the pre-normalisation exponent and the operand signs consumed by the downstream normaliser/rounder stage.

Parameters:
- SHIFT_STEP, 4, maximum alignment shift applied per ALIGN cycle (legal 1..25).
- ALIGN_LIMIT, 25, exponent difference at or above which the smaller mantissa is flushed to zero without shifting.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept; equals (state==IDLE)
- a  in  32  operand A, binary32
- b  in  32  operand B, binary32
- op  in  1  0=A+B, 1=A-B
- out_valid  out  1  result registers valid
- out_ready  in  1  downstream accepts result
- sum  out  25  raw mantissa sum/difference; bit24=carry, bit23=hidden position
- new_exponent  out  8  exponent of larger-magnitude operand
- sign_a  out  1  sign of larger-magnitude operand (X)
- sign_b  out  1  effective sign of smaller operand (Y), after op inversion
- result_sign  out  1  sign of the final result
- exc_operand  out  1  either input exponent == 8'hFF

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid, sum, new_exponent, sign_a, sign_b, result_sign and exc_operand are 0; internal mx, my, ex and diff are 0. in_ready reads 1 during and after reset. Reset asserted mid-operation aborts the operation and produces no output.
- FSM states: IDLE, ALIGN, ADD, HOLD.
- IDLE, on in_valid (accept edge T0):
  - Unpack each operand: hidden bit = (exp != 0); mantissa = {hidden, frac}, 24 bits.
  - Effective sign of B is b[31]^op.
  - Swap so X holds the larger {exp, frac}; ties keep A as X.
  - diff = ex - ey. If diff >= ALIGN_LIMIT: my=0, diff=0.
  - Latch exc_operand.
  - Next state: ALIGN if diff != 0, else ADD.
- ALIGN: each cycle my >>= min(diff, SHIFT_STEP) and diff -= that amount. Go to ADD on the cycle diff reaches 0. Shifted-out bits are discarded; there is no sticky bit.
- ADD:
  - If sign_x == sign_y: sum = mx + my, 25 bits.
  - Otherwise: sum = {1'b0, mx - my}. This never underflows, because X is the larger magnitude.
  - new_exponent = ex. sign_a = sign_x, sign_b = sign_y.
  - result_sign = sign_x, except it is forced to 0 when the difference is exactly zero.
  - out_valid <= 1; go to HOLD.
- HOLD: all outputs are held stable while out_ready=0. On out_ready=1, out_valid <= 0 and state goes to IDLE. The next accept is possible in the following cycle; there is no same-cycle turnaround.
- Latency: out_valid rises after edge T0 + 1 + ceil(d / SHIFT_STEP), where d is diff after the flush rule. This is exactly T0+1 when d=0.
- Output registers change only on the ADD transition or on reset.
- Denormals are treated as hidden=0 with their true exponent field 0; no special re-biasing is done.
- exc_operand does not alter the datapath; it is flagged only.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W=8, MANT_W=23, SUM_W=25, EXP_MAX=8'hFF, BIAS=127
  - the FSM state enum {IDLE, ALIGN, ADD, HOLD}
  - an unpacked-operand struct {sign, exp[7:0], mant[23:0]}
- Sub-module fp_unpack (combinational): binary32 in -> sign, exp and hidden-bit mantissa, plus an is_inf_nan flag. It is instantiated twice.

Test Plan (SHIFT_STEP=4):
- a=0x3F800000, b=0x3F800000, op=0 -> sum=0x1000000, new_exponent=0x7F, sign_a=sign_b=0, out_valid at T0+1.
- a=0x3F800000, b=0x3F000000, op=0 -> my aligned to 0x400000, sum=0x0C00000, new_exponent=0x7F, out_valid at T0+2.
- a=0x3F000000, b=0xBF800000, op=0 -> swap: sign_a=1, sign_b=0, sum=0x0400000, new_exponent=0x7F, result_sign=1.
- a=0x3F800000, b=0x3F800000, op=1 -> sum=0, sign_a=0, sign_b=1, result_sign=0; then a=0x4B800000, b=0x3F000000 (diff 25) -> sum=0x0800000, new_exponent=0x97, out_valid at T0+1.
- a=0x7F800000, b=0x3F800000 -> exc_operand=1, out_valid still asserted; then hold out_ready=0 for 5 cycles -> outputs unchanged, in_ready=0.
- Assert rst_n=0 during ALIGN (a=0x41200000, b=0x3F800000) -> out_valid=0 and all outputs 0 immediately, in_ready=1; after reset release, a fresh accept completes normally.
